mul_datapath_ctrl: RTL and testbench

MUL_DATAPATH_CTRL -- requirements
Module: mul_datapath_ctrl

---
 rtl/mul_datapath_ctrl.sv | 126 ++++++++++++
 tb/tb_mul_datapath_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mul_datapath_ctrl.sv
// mul_datapath_ctrl
//   Unsigned shift-free multiplier built from repeated addition. A controller
//   loads operand A, then operand B, from one shared bus, and adds A into the
//   product register P once per cycle while counting B down to zero. The
//   product is A*B mod 2^WIDTH.
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   begin a multiplication (only looked at in IDLE)
//   data_in  in   WIDTH  operand bus: A in LOAD_A, B in LOAD_B
//   y        out  WIDTH  product register P
//   done     out  high while the result in y is final (DONE state)
//
// Controller states
//   state  | meaning
//   IDLE   | waiting for start, registers untouched
//   LOAD_A | capture A from data_in
//   LOAD_B | capture B from data_in, clear P
//   MULT   | P += A and B -= 1 each cycle until B reaches zero
//   DONE   | result held; leave once start is released

module mul_datapath_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] y,
    output logic             done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_MULT   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;

    logic ld_a, ld_b, ld_p, clr_p, dec_b;
    logic eqz;

    assign eqz = (b_q == '0);

    // Controller: next state and Moore control strobes
    always_comb begin
        state_d = state_q;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        ld_p    = 1'b0;
        clr_p   = 1'b0;
        dec_b   = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD_A;
            end
            ST_LOAD_A: begin
                ld_a    = 1'b1;
                state_d = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                ld_b    = 1'b1;
                clr_p   = 1'b1;
                state_d = ST_MULT;
            end
            ST_MULT: begin
                if (eqz) begin
                    state_d = ST_DONE;
                end else begin
                    ld_p  = 1'b1;
                    dec_b = 1'b1;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                // Stay here until start drops so a held start cannot retrigger.
                if (!start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        p_d = p_q;
        if (ld_a) a_d = data_in;
        if (ld_b) begin
            b_d = data_in;
        end else if (dec_b) begin
            // dec_b is only raised when B is non-zero, so this never wraps.
            b_d = b_q - 1'b1;
        end
        if (clr_p) begin
            p_d = '0;
        end else if (ld_p) begin
            p_d = p_q + a_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
        end
    end

    assign y = p_q;

endmodule

// File: tb/tb_mul_datapath_ctrl.sv
module tb_mul_datapath_ctrl;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] y;
    logic             done;

    int checks;
    int errors;
    int prev_y;

    mul_datapath_ctrl #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .data_in (data_in),
        .y       (y),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // advance one rising edge, settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int modw(input longint v);
        return int'(v % 65536);
    endfunction

    // Drive one full multiplication from IDLE. Reference: product is a*b mod
    // 2^16, y after the i-th loop edge is a*i mod 2^16, done comes b+3 edges
    // after the start edge. start and data_in are randomized wherever they
    // are supposed to be ignored.
    task automatic run_op(input int a, input int b, input int hold);
        int prod;
        prod = modw(longint'(a) * longint'(b));
        start   = 1'b1;
        data_in = WIDTH'($urandom);
        step();                                   // edge k: -> LOAD_A
        chk("ldA_done", int'(done), 0);
        chk("ldA_y_hold", int'(y), prev_y);
        start   = 1'($urandom);
        data_in = WIDTH'(a);
        step();                                   // edge k+1: A captured
        chk("ldB_done", int'(done), 0);
        chk("ldB_y_hold", int'(y), prev_y);
        start   = 1'($urandom);
        data_in = WIDTH'(b);
        step();                                   // edge k+2: B captured, P cleared
        chk("mult_y0", int'(y), 0);
        chk("mult_done0", int'(done), 0);
        for (int i = 1; i <= b; i++) begin
            start   = 1'($urandom);
            data_in = WIDTH'($urandom);
            step();
            chk("mult_y_step", int'(y), modw(longint'(a) * longint'(i)));
            chk("mult_done", int'(done), 0);
        end
        start   = 1'($urandom);
        data_in = WIDTH'($urandom);
        step();                                   // edge k+3+b: -> DONE
        chk("done_rise", int'(done), 1);
        chk("done_y", int'(y), prod);
        prev_y = prod;
        for (int h = 0; h < hold; h++) begin
            start   = 1'b1;
            data_in = WIDTH'($urandom);
            step();
            chk("done_hold", int'(done), 1);
            chk("done_hold_y", int'(y), prod);
        end
        start   = 1'b0;
        data_in = WIDTH'($urandom);
        step();                                   // -> IDLE
        chk("idle_done", int'(done), 0);
        chk("idle_y_retained", int'(y), prod);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        prev_y  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = '0;
        #3;
        chk("reset_y", int'(y), 0);
        chk("reset_done", int'(done), 0);
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_reset_idle_done", int'(done), 0);
        chk("post_reset_idle_y", int'(y), 0);

        // idle with start low: nothing should move
        for (int i = 0; i < 3; i++) begin
            data_in = WIDTH'($urandom);
            step();
            chk("idle_quiet_done", int'(done), 0);
            chk("idle_quiet_y", int'(y), 0);
        end

        run_op(17, 5, 3);
        run_op(9, 0, 1);
        run_op(0, 7, 0);
        run_op(300, 300, 1);
        run_op(3, 2, 0);

        // abort during MULT with async reset
        start   = 1'b1;
        data_in = WIDTH'($urandom);
        step();
        start   = 1'b0;
        data_in = 16'd17;
        step();
        data_in = 16'd5;
        step();
        step();
        step();
        chk("pre_abort_y", int'(y), 34);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_y", int'(y), 0);
        chk("abort_done", int'(done), 0);
        prev_y = 0;
        step();
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        step();
        chk("abort_idle_done", int'(done), 0);
        chk("abort_idle_y", int'(y), 0);
        run_op(6, 4, 0);

        // randomized operations
        for (int n = 0; n < 20; n++) begin
            run_op(int'($urandom_range(0, 65535)), int'($urandom_range(0, 40)),
                   int'($urandom_range(0, 3)));
        end
        run_op(65535, 2, 0);
        run_op(65535, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
